ofifo_psum: RTL and testbench

- Output-collection buffer directly downstream of the mac_col chain.
- One independent FIFO per MAC column captures that column's 32-bit psum whenever the column pulses its fifo_wr.
- Presents a full row of psums, one per column, once every column has at least one entry.
- Drained by the output/SFU read logic via a single row-pop handshake.

---
 rtl/ofifo_psum_pkg.sv | 11 +
 rtl/ofifo_psum_fifo_lane.sv | 46 ++++
 rtl/ofifo_psum.sv | 53 +++++
 tb/tb_ofifo_psum.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ofifo_psum_pkg.sv
// Shared widths and instruction encodings for the PE array datapath.
// Defaults here are the same values used by mac_col so the two stay in step.
package ofifo_psum_pkg;
  localparam int BW      = 8;
  localparam int BW_PSUM = 32;
  localparam int COL     = 8;
  localparam int PR      = 8;

  localparam logic [1:0] INSTR_IDLE    = 2'b00;
  localparam logic [1:0] INSTR_EXECUTE = 2'b01;
endpackage

// File: rtl/ofifo_psum_fifo_lane.sv
// Single-lane first-word-fall-through FIFO holding one column's psums.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module fifo_lane
  import ofifo_psum_pkg::*;
#(
  parameter int bw_psum = BW_PSUM,
  parameter int depth   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               pop,
  input  logic [bw_psum-1:0] din,
  output logic [bw_psum-1:0] dout,
  output logic               empty,
  output logic               full
);
  localparam int AW = $clog2(depth);

  logic [AW:0]        rd_ptr, wr_ptr;
  logic [bw_psum-1:0] mem [depth];
  logic               accept, do_pop;

  assign empty  = (rd_ptr == wr_ptr);
  assign full   = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  // A pop frees the head slot in the same edge, so a full lane may still take a write.
  assign accept = wr & (~full | pop);
  assign do_pop = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Storage is never cleared, so an empty lane masks its head to zero.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/ofifo_psum.sv
// Per-column psum collection buffer: one FIFO lane per MAC column, popped a full row at a time.
// Status flags come from registered pointers only so the downstream handshake has no comb loop.
module ofifo_psum
  import ofifo_psum_pkg::*;
#(
  parameter int col     = COL,
  parameter int bw_psum = BW_PSUM,
  parameter int depth   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw_psum-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);
  logic [col-1:0] empty;
  logic [col-1:0] full;
  logic           pop;

  assign o_valid = &(~empty);
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;

  for (genvar k = 0; k < col; k++) begin : g_lane
    fifo_lane #(
      .bw_psum(bw_psum),
      .depth  (depth)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .wr   (wr[k]),
      .pop  (pop),
      .din  (in[k*bw_psum +: bw_psum]),
      .dout (out[k*bw_psum +: bw_psum]),
      .empty(empty[k]),
      .full (full[k])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_overflow <= 1'b0;
    end else if (|(wr & full & {col{~pop}})) begin
      o_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ofifo_psum.sv
// Directed bench for ofifo_psum: reset, staggered fill, wrap, overflow, pop-with-write, async reset.
module tb_ofifo_psum;
  localparam int COLS = 8;
  localparam int BWP  = 32;
  localparam int BUSW = COLS * BWP;

  logic            clk = 1'b0;
  logic            reset;
  logic [BUSW-1:0] in_bus;
  logic [COLS-1:0] wr;
  logic            rd;
  logic [BUSW-1:0] out_bus;
  logic            o_valid, o_full, o_ready, o_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  ofifo_psum #(.col(COLS), .bw_psum(BWP), .depth(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_bus),
    .wr        (wr),
    .rd        (rd),
    .out       (out_bus),
    .o_valid   (o_valid),
    .o_full    (o_full),
    .o_ready   (o_ready),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BUSW-1:0] act, input logic [BUSW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [BUSW-1:0] mkrow(input int base);
    logic [BUSW-1:0] r;
    r = '0;
    for (int k = 0; k < COLS; k++) r[k*BWP +: BWP] = 32'(base + k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rows();
    for (int r = 0; r < 8; r++) begin
      in_bus = mkrow(16 * r);
      wr     = '1;
      tick();
      check("fill_full", BUSW'(o_full), BUSW'(r == 7));
    end
    wr = '0;
  endtask

  task automatic pop_row();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_bus = '0; wr = '0; rd = 1'b0;

    // reset then idle
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_valid", BUSW'(o_valid), '0);
    check("rst_ready", BUSW'(o_ready), BUSW'(1));
    check("rst_full", BUSW'(o_full), '0);
    check("rst_ovf", BUSW'(o_overflow), '0);
    check("rst_out", out_bus, '0);

    // staggered column writes, lane k one cycle after lane k-1
    for (int k = 0; k < 8; k++) begin
      in_bus = mkrow(100);
      wr     = COLS'(1) << k;
      tick();
      check("stag_valid", BUSW'(o_valid), BUSW'(k == 7));
    end
    wr = '0;
    check("stag_out", out_bus, mkrow(100));
    pop_row();
    check("stag_pop_valid", BUSW'(o_valid), '0);
    check("stag_pop_out", out_bus, '0);

    // fill, drain in order, then write across the pointer wrap
    fill_rows();
    check("fill_ready", BUSW'(o_ready), '0);
    for (int r = 0; r < 8; r++) begin
      check("drain_row", out_bus, mkrow(16 * r));
      pop_row();
    end
    check("drain_empty", BUSW'(o_valid), '0);
    for (int r = 0; r < 3; r++) begin
      in_bus = mkrow(300 + 16 * r);
      wr     = '1;
      tick();
    end
    wr = '0;
    check("wrap_full", BUSW'(o_full), '0);
    for (int r = 0; r < 3; r++) begin
      check("wrap_row", out_bus, mkrow(300 + 16 * r));
      pop_row();
    end
    check("wrap_empty", BUSW'(o_valid), '0);

    // simultaneous pop and write while full
    fill_rows();
    in_bus = mkrow(900);
    wr     = '1;
    rd     = 1'b1;
    tick();
    wr = '0; rd = 1'b0;
    check("pw_full", BUSW'(o_full), BUSW'(1));
    check("pw_ovf", BUSW'(o_overflow), '0);
    for (int r = 1; r < 8; r++) begin
      check("pw_row", out_bus, mkrow(16 * r));
      pop_row();
    end
    check("pw_last", out_bus, mkrow(900));
    pop_row();
    check("pw_empty", BUSW'(o_valid), '0);

    // dropped write into a full lane
    fill_rows();
    in_bus = '0;
    in_bus[31:0] = 32'hDEAD;
    wr = 8'h01;
    tick();
    wr = '0;
    check("ovf_flag", BUSW'(o_overflow), BUSW'(1));
    check("ovf_head0", BUSW'(out_bus[31:0]), '0);
    check("ovf_full", BUSW'(o_full), BUSW'(1));
    for (int r = 0; r < 8; r++) begin
      check("ovf_row", out_bus, mkrow(16 * r));
      pop_row();
    end
    check("ovf_empty", BUSW'(o_valid), '0);
    check("ovf_sticky", BUSW'(o_overflow), BUSW'(1));

    // asynchronous reset with rows buffered
    for (int r = 0; r < 3; r++) begin
      in_bus = mkrow(200 + 16 * r);
      wr     = '1;
      tick();
    end
    wr = '0;
    check("ar_pre_valid", BUSW'(o_valid), BUSW'(1));
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid", BUSW'(o_valid), '0);
    check("ar_ready", BUSW'(o_ready), BUSW'(1));
    check("ar_ovf", BUSW'(o_overflow), '0);
    check("ar_out", out_bus, '0);
    tick();
    reset = 1'b1;
    tick();
    in_bus = mkrow(500);
    wr     = '1;
    tick();
    wr = '0;
    check("ar_new_valid", BUSW'(o_valid), BUSW'(1));
    check("ar_new_out", out_bus, mkrow(500));
    pop_row();
    check("ar_new_empty", BUSW'(o_valid), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
